l2_arbiter: RTL and testbench

- Shares the single unified L2 cache between the L1 instruction cache (read-only) and the L1 data cache (read/write).
- Sits between the two L1 miss ports and the L2 mem_* port.
- Serialises one line transaction at a time and latches the winner's command, address and data for the whole service.
- Enforces an idle gap after every L2 response, because the L2 registers its inputs one cycle late and must not see a stale request.

---
 rtl/l2_arbiter_pkg.sv | 33 +++
 rtl/l2_arbiter_select.sv | 36 +++
 rtl/l2_arbiter.sv | 169 ++++++++++++++++
 tb/tb_l2_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arbiter_pkg.sv
// Shared LC-3b memory-hierarchy types used by the L1/L2 arbiter.
// Holds the arbiter state and requester encodings plus the gap-counter load helper.
package lc3b_types;

  localparam int unsigned LC3B_WORD_W = 16;
  localparam int unsigned LC3B_LINE_W = 128;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_cacheline;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    GAP
  } lc3b_arb_state;

  typedef enum logic {
    REQ_I,
    REQ_D
  } lc3b_requester;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } lc3b_mem_op;

  // The counter holds "GAP cycles still to go after this one", so it loads one less than the gap length.
  function automatic logic [1:0] gapLoad(input int unsigned cycles);
    return 2'(cycles - 1);
  endfunction

endpackage

// File: rtl/l2_arbiter_select.sv
// Combinational grant selection between the I-cache and D-cache miss ports.
// A tie goes to D when FIXED_PRIO is set, otherwise to whichever side was not granted last.
module l2_arbiter_select
  import lc3b_types::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic i_pendI,
  input  logic i_pendD,
  input  logic i_lastGrant,
  output logic o_grantI,
  output logic o_grantD,
  output logic o_tie
);

  logic w_lastWasD;

  assign w_lastWasD = (lc3b_requester'(i_lastGrant) == REQ_D);

  always_comb begin
    o_tie    = i_pendI & i_pendD;
    o_grantI = 1'b0;
    o_grantD = 1'b0;
    if (o_tie) begin
      if ((FIXED_PRIO != 0) || !w_lastWasD) begin
        o_grantD = 1'b1;
      end else begin
        o_grantI = 1'b1;
      end
    end else begin
      o_grantI = i_pendI;
      o_grantD = i_pendD;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Arbiter sharing the unified L2 between the L1 I-cache and D-cache, one line at a time.
// The winner's command is latched for the whole service and an idle gap follows every L2 response.
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int          ADDR_W     = $bits(lc3b_word),
  parameter int          LINE_W     = $bits(lc3b_cacheline),
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata,
  output logic              contention_inc
);

  localparam logic [1:0] GAP_INIT = gapLoad(GAP_CYCLES);

  lc3b_arb_state     r_state;
  lc3b_arb_state     w_nextState;
  lc3b_requester     r_lastGrant;
  lc3b_mem_op        r_op;
  logic [1:0]        r_gapCnt;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_contention;

  logic w_pendI;
  logic w_pendD;
  logic w_grantI;
  logic w_grantD;
  logic w_tie;
  logic w_idle;

  assign w_pendI = i_read;
  assign w_pendD = d_read | d_write;
  assign w_idle  = (r_state == IDLE);

  l2_arbiter_select #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_select (
    .i_pendI    (w_pendI),
    .i_pendD    (w_pendD),
    .i_lastGrant(r_lastGrant),
    .o_grantI   (w_grantI),
    .o_grantD   (w_grantD),
    .o_tie      (w_tie)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_grantD) begin
          w_nextState = SERVE_D;
        end else if (w_grantI) begin
          w_nextState = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          w_nextState = GAP;
        end
      end
      GAP: begin
        if (r_gapCnt == 2'd0) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Command latches only move on a grant edge, so requester changes mid-service are invisible to the L2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_op        <= OP_READ;
      r_lastGrant <= REQ_I;
    end else if (w_idle && w_grantD) begin
      r_addr      <= d_address;
      r_wdata     <= d_wdata;
      r_op        <= d_write ? OP_WRITE : OP_READ;
      r_lastGrant <= REQ_D;
    end else if (w_idle && w_grantI) begin
      r_addr      <= i_address;
      r_op        <= OP_READ;
      r_lastGrant <= REQ_I;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_contention <= 1'b0;
    end else begin
      r_contention <= w_idle & w_tie;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gapCnt <= 2'd0;
    end else if (((r_state == SERVE_I) || (r_state == SERVE_D)) && l2_resp) begin
      r_gapCnt <= GAP_INIT;
    end else if ((r_state == GAP) && (r_gapCnt != 2'd0)) begin
      r_gapCnt <= r_gapCnt - 2'd1;
    end
  end

  // Responses pass straight through in the serving state only; a stray l2_resp elsewhere reaches nobody.
  always_comb begin
    l2_read  = 1'b0;
    l2_write = 1'b0;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;
    case (r_state)
      SERVE_I: begin
        l2_read = 1'b1;
        i_resp  = l2_resp;
        if (l2_resp) begin
          i_rdata = l2_rdata;
        end
      end
      SERVE_D: begin
        l2_read  = (r_op == OP_READ);
        l2_write = (r_op == OP_WRITE);
        d_resp   = l2_resp;
        if (l2_resp) begin
          d_rdata = l2_rdata;
        end
      end
      default: begin
        l2_read  = 1'b0;
        l2_write = 1'b0;
      end
    endcase
  end

  assign l2_address     = r_addr;
  assign l2_wdata       = r_wdata;
  assign contention_inc = r_contention;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: two instances (round-robin/gap 1 and fixed-D/gap 3) share the L1 request pins.
// A transaction-level model predicts every output each cycle; directed literals pin the model itself.
module tb_l2_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n    = 1'b1;
  logic          iRead    = 1'b0;
  logic [15:0]   iAddress = '0;
  logic          dRead    = 1'b0;
  logic          dWrite   = 1'b0;
  logic [15:0]   dAddress = '0;
  logic [127:0]  dWdata   = '0;

  logic          l2Resp   [N];
  logic [127:0]  l2Rdata  [N];
  logic          iRespO   [N];
  logic [127:0]  iRdataO  [N];
  logic          dRespO   [N];
  logic [127:0]  dRdataO  [N];
  logic          l2ReadO  [N];
  logic          l2WriteO [N];
  logic [15:0]   l2AddrO  [N];
  logic [127:0]  l2WdataO [N];
  logic          contO    [N];

  int            nChecks = 0;
  int            nPass   = 0;
  bit            checkEn = 1'b0;

  int            respLat = 5;
  logic [127:0]  respData [N];
  logic          strayReq [N];
  int            busyCnt  [N];

  l2_arbiter #(.GAP_CYCLES(1), .FIXED_PRIO(0)) dutA (
    .clk(clk), .rst_n(rst_n),
    .i_read(iRead), .i_address(iAddress), .i_resp(iRespO[0]), .i_rdata(iRdataO[0]),
    .d_read(dRead), .d_write(dWrite), .d_address(dAddress), .d_wdata(dWdata),
    .d_resp(dRespO[0]), .d_rdata(dRdataO[0]),
    .l2_read(l2ReadO[0]), .l2_write(l2WriteO[0]), .l2_address(l2AddrO[0]), .l2_wdata(l2WdataO[0]),
    .l2_resp(l2Resp[0]), .l2_rdata(l2Rdata[0]), .contention_inc(contO[0])
  );

  l2_arbiter #(.GAP_CYCLES(3), .FIXED_PRIO(1)) dutB (
    .clk(clk), .rst_n(rst_n),
    .i_read(iRead), .i_address(iAddress), .i_resp(iRespO[1]), .i_rdata(iRdataO[1]),
    .d_read(dRead), .d_write(dWrite), .d_address(dAddress), .d_wdata(dWdata),
    .d_resp(dRespO[1]), .d_rdata(dRdataO[1]),
    .l2_read(l2ReadO[1]), .l2_write(l2WriteO[1]), .l2_address(l2AddrO[1]), .l2_wdata(l2WdataO[1]),
    .l2_resp(l2Resp[1]), .l2_rdata(l2Rdata[1]), .contention_inc(contO[1])
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // L2 stand-in: answers respLat cycles into a request, or fires a one-off stray pulse on demand.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      l2Resp[k]  = 1'b0;
      l2Rdata[k] = '0;
      if (!rst_n) begin
        busyCnt[k] = 0;
      end else if (strayReq[k]) begin
        l2Resp[k]   = 1'b1;
        l2Rdata[k]  = {4{32'hDEADBEEF}};
        strayReq[k] = 1'b0;
      end else if (l2ReadO[k] || l2WriteO[k]) begin
        busyCnt[k]++;
        if (busyCnt[k] >= respLat) begin
          l2Resp[k]  = 1'b1;
          l2Rdata[k] = respData[k];
          busyCnt[k] = 0;
        end
      end else begin
        busyCnt[k] = 0;
      end
    end
  end

  // Transaction model: who owns the L2, what was latched, and how many quiet cycles remain.
  int           mOwner   [N] = '{0, 0};
  logic         mOpWr    [N] = '{1'b0, 1'b0};
  logic [15:0]  mAddr    [N] = '{16'h0, 16'h0};
  logic [127:0] mWdata   [N] = '{128'h0, 128'h0};
  int           mGapLeft [N] = '{0, 0};
  logic         mLastD   [N] = '{1'b0, 1'b0};
  logic         mCont    [N] = '{1'b0, 1'b0};

  function automatic int gapOf(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit fixedOf(input int k);
    return (k == 0) ? 1'b0 : 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : modelStep
    logic pI, pD, takeD;
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        mOwner[k] <= 0; mOpWr[k] <= 1'b0; mAddr[k] <= '0; mWdata[k] <= '0;
        mGapLeft[k] <= 0; mLastD[k] <= 1'b0; mCont[k] <= 1'b0;
      end else begin
        mCont[k] <= 1'b0;
        pI = iRead;
        pD = dRead | dWrite;
        if (mOwner[k] != 0) begin
          if (l2Resp[k]) begin
            mOwner[k]   <= 0;
            mGapLeft[k] <= gapOf(k);
          end
        end else if (mGapLeft[k] > 0) begin
          mGapLeft[k] <= mGapLeft[k] - 1;
        end else if (pI || pD) begin
          takeD = pD && (!pI || fixedOf(k) || !mLastD[k]);
          mCont[k]  <= pI && pD;
          mLastD[k] <= takeD;
          if (takeD) begin
            mOwner[k] <= 2; mAddr[k] <= dAddress; mWdata[k] <= dWdata; mOpWr[k] <= dWrite;
          end else begin
            mOwner[k] <= 1; mAddr[k] <= iAddress; mOpWr[k] <= 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < N; k++) begin
        logic eIResp, eDResp;
        eIResp = (mOwner[k] == 1) && l2Resp[k];
        eDResp = (mOwner[k] == 2) && l2Resp[k];
        checkOutput($sformatf("dut%0d.l2_read", k), 128'(l2ReadO[k]),
                    128'((mOwner[k] == 1) || ((mOwner[k] == 2) && !mOpWr[k])));
        checkOutput($sformatf("dut%0d.l2_write", k), 128'(l2WriteO[k]), 128'((mOwner[k] == 2) && mOpWr[k]));
        checkOutput($sformatf("dut%0d.l2_address", k), 128'(l2AddrO[k]), 128'(mAddr[k]));
        checkOutput($sformatf("dut%0d.l2_wdata", k), l2WdataO[k], mWdata[k]);
        checkOutput($sformatf("dut%0d.i_resp", k), 128'(iRespO[k]), 128'(eIResp));
        checkOutput($sformatf("dut%0d.d_resp", k), 128'(dRespO[k]), 128'(eDResp));
        checkOutput($sformatf("dut%0d.i_rdata", k), iRdataO[k], eIResp ? l2Rdata[k] : 128'h0);
        checkOutput($sformatf("dut%0d.d_rdata", k), dRdataO[k], eDResp ? l2Rdata[k] : 128'h0);
        checkOutput($sformatf("dut%0d.contention_inc", k), 128'(contO[k]), 128'(mCont[k]));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                               input logic [15:0] da, input logic [127:0] dwd);
    iRead = ir; iAddress = ia; dRead = dr; dWrite = dw; dAddress = da; dWdata = dwd;
  endtask

  function automatic logic sigOf(input int sel, input int k);
    case (sel)
      0:       return iRespO[k];
      1:       return dRespO[k];
      default: return l2Resp[k];
    endcase
  endfunction

  task automatic waitFor(input string what, input int sel, input int k, output int waited);
    waited = 0;
    while (!sigOf(sel, k) && waited < 40) begin
      tick(1);
      waited++;
    end
    if (!sigOf(sel, k)) checkOutput({what, ".timeout"}, 128'(0), 128'(1));
  endtask

  task automatic countQuiet(input int k, output int cnt);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (l2ReadO[k] || l2WriteO[k]) break;
      cnt++;
    end
  endtask

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] W1 = {4{32'h11112222}};
  localparam logic [127:0] W2 = {4{32'h33334444}};
  localparam logic [127:0] W3 = {4{32'h55556666}};
  localparam logic [127:0] W4 = {4{32'h77778888}};
  localparam logic [127:0] W5 = {4{32'h9999AAAA}};

  initial begin
    int waited;
    int quiet;
    for (int k = 0; k < N; k++) begin
      l2Resp[k] = 1'b0; l2Rdata[k] = '0; strayReq[k] = 1'b0; busyCnt[k] = 0; respData[k] = LINE_A5;
    end
    #1 rst_n = 1'b0;
    applyStimulus(1'b1, 16'h1230, 1'b0, 1'b0, 16'h0, '0);
    tick(1);
    checkEn = 1'b1;
    tick(2);
    checkOutput("reset.l2_read", 128'(l2ReadO[0]), 128'(0));
    checkOutput("reset.l2_address", 128'(l2AddrO[0]), 128'(0));
    checkOutput("reset.i_resp", 128'(iRespO[0]), 128'(0));
    checkOutput("reset.contention_inc", 128'(contO[0]), 128'(0));

    rst_n = 1'b1;
    tick(1);
    checkOutput("grantI.l2_read", 128'(l2ReadO[0]), 128'(1));
    checkOutput("grantI.l2_address", 128'(l2AddrO[0]), 128'(16'h1230));
    checkOutput("grantI.fixed.l2_read", 128'(l2ReadO[1]), 128'(1));
    waitFor("iread.i_resp", 0, 0, waited);
    checkOutput("iread.latency", 128'(waited), 128'(4));
    checkOutput("iread.i_rdata", iRdataO[0], LINE_A5);
    checkOutput("iread.d_resp", 128'(dRespO[0]), 128'(0));
    applyStimulus(1'b0, 16'h1230, 1'b0, 1'b0, 16'h0, '0);
    tick(1);
    checkOutput("iread.gap_l2_read", 128'(l2ReadO[0]), 128'(0));
    tick(6);

    rst_n = 1'b0;
    respData[0] = {8{16'h5A3C}};
    respData[1] = {8{16'h5A3C}};
    applyStimulus(1'b1, 16'h2000, 1'b0, 1'b1, 16'h0040, W1);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checkOutput("tie.l2_write", 128'(l2WriteO[0]), 128'(1));
    checkOutput("tie.l2_read", 128'(l2ReadO[0]), 128'(0));
    checkOutput("tie.l2_address", 128'(l2AddrO[0]), 128'(16'h0040));
    checkOutput("tie.l2_wdata", l2WdataO[0], W1);
    checkOutput("tie.contention_inc", 128'(contO[0]), 128'(1));
    checkOutput("tie.fixed.l2_write", 128'(l2WriteO[1]), 128'(1));
    applyStimulus(1'b1, 16'h2000, 1'b0, 1'b1, 16'hFFF0, W2);
    tick(1);
    checkOutput("latch.contention_once", 128'(contO[0]), 128'(0));
    checkOutput("latch.l2_address", 128'(l2AddrO[0]), 128'(16'h0040));
    checkOutput("latch.l2_wdata", l2WdataO[0], W1);
    waitFor("tie.d_resp", 1, 0, waited);
    checkOutput("tie.d_rdata", dRdataO[0], {8{16'h5A3C}});
    checkOutput("tie.i_resp", 128'(iRespO[0]), 128'(0));
    applyStimulus(1'b1, 16'h2000, 1'b0, 1'b0, 16'h0040, '0);
    tick(2);
    checkOutput("rr.idle_low", 128'(l2ReadO[0]), 128'(0));
    tick(1);
    checkOutput("rr.i_after_gap", 128'(l2ReadO[0]), 128'(1));
    checkOutput("rr.i_address", 128'(l2AddrO[0]), 128'(16'h2000));
    waitFor("rr.i_resp", 0, 0, waited);
    applyStimulus(1'b0, 16'h2000, 1'b0, 1'b0, 16'h0, '0);
    tick(12);

    applyStimulus(1'b1, 16'h3000, 1'b0, 1'b1, 16'h0080, W3);
    tick(1);
    checkOutput("tie2.l2_write", 128'(l2WriteO[0]), 128'(1));
    checkOutput("tie2.l2_address", 128'(l2AddrO[0]), 128'(16'h0080));
    checkOutput("tie2.contention_inc", 128'(contO[0]), 128'(1));
    waitFor("tie2.d_resp", 1, 0, waited);
    applyStimulus(1'b1, 16'h3000, 1'b0, 1'b0, 16'h0080, '0);
    waitFor("tie2.i_resp", 0, 0, waited);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);
    tick(12);

    applyStimulus(1'b1, 16'h4000, 1'b1, 1'b1, 16'h0100, W4);
    tick(1);
    checkOutput("illegal.l2_write", 128'(l2WriteO[1]), 128'(1));
    checkOutput("illegal.l2_read", 128'(l2ReadO[1]), 128'(0));
    waitFor("gap3.l2_resp", 2, 1, waited);
    strayReq[1] = 1'b1;
    tick(1);
    checkOutput("stray_gap.d_resp", 128'(dRespO[1]), 128'(0));
    checkOutput("stray_gap.i_resp", 128'(iRespO[1]), 128'(0));
    countQuiet(1, quiet);
    // Three GAP cycles, then the IDLE cycle in which the waiting request is sampled.
    checkOutput("gap3.quiet_cycles", 128'(quiet + 1), 128'(4));
    waitFor("gap1.l2_resp", 2, 0, waited);
    countQuiet(0, quiet);
    checkOutput("gap1.quiet_cycles", 128'(quiet), 128'(2));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);
    tick(15);

    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h0200, W5);
    tick(2);
    checkOutput("rstmid.pre_l2_write", 128'(l2WriteO[0]), 128'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid.l2_write", 128'(l2WriteO[0]), 128'(0));
    checkOutput("rstmid.fixed.l2_write", 128'(l2WriteO[1]), 128'(0));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, '0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    strayReq[0] = 1'b1;
    strayReq[1] = 1'b1;
    tick(1);
    checkOutput("rstmid.stray_d_resp", 128'(dRespO[0]), 128'(0));
    checkOutput("rstmid.fixed.stray_d_resp", 128'(dRespO[1]), 128'(0));
    tick(3);

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
